// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  // Width of one transmitted byte.
  localparam int BYTE_W = 8;

  // Arbiter phases: pick a producer, pulse start, wait for busy to rise, wait for the frame to end.
  typedef enum logic [1:0] {
    ARB       = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte producers, the arbiter and uart_tx.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_tx_arbiter_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_busy;
  logic                      tx_start;
  logic [BYTE_W-1:0]         tx_data;
  logic [IDX_W-1:0]          grant_id;
  logic                      arb_busy;
  logic                      err_timeout;

  // Producer/uart_tx side of the bundle.
  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_start, tx_data, grant_id, arb_busy, err_timeout
  );

  // Arbiter side of the bundle.
  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_start, tx_data, grant_id, arb_busy, err_timeout
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin select: first set request at or after the start pointer, with wrap.
module uart_tx_arbiter_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [$clog2(N)-1:0] o_winner,
  output logic                 o_found
);

  localparam int IDX_W = $clog2(N);
  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] w_sum;
  logic [IDX_W-1:0] w_idx;

  // Walk N slots from the pointer; the wrap is an explicit compare so non-power-of-2 N never aliases.
  always_comb begin
    o_winner = '0;
    o_found  = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + SUM_W'(k);
      if (w_sum >= SUM_W'(N)) begin
        w_sum = w_sum - SUM_W'(N);
      end
      w_idx = w_sum[IDX_W-1:0];
      if (!o_found && i_req[w_idx]) begin
        o_winner = w_idx;
        o_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between several byte producers, with burst hold and ack timeout.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TO_W  = $clog2(ACK_TIMEOUT);

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_grant_id;
  logic [3:0]        r_burst_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_tx_start;
  logic [BYTE_W-1:0] r_tx_data;
  logic              r_err_timeout;

  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_found;
  logic              w_hold;
  logic [IDX_W-1:0]  w_winner;
  logic              w_accept;
  logic [3:0]        w_burst_next;
  logic              w_hold_ends;
  logic              w_timeout;
  logic [BYTE_W-1:0] w_sel_data;

  // Next index with explicit wrap at NUM_REQ-1.
  function automatic logic [IDX_W-1:0] incWrap(input logic [IDX_W-1:0] v);
    if (v == IDX_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return v + IDX_W'(1);
  endfunction

  uart_tx_arbiter_rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .i_req    (bus.req_valid),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_pick_idx),
    .o_found  (w_pick_found)
  );

  // Winner: keep the current requester while its burst is open and it still has data, else round-robin.
  always_comb begin
    w_hold       = (r_burst_cnt != 4'd0) && (r_burst_cnt < 4'(MAX_BURST)) && bus.req_valid[r_grant_id];
    w_winner     = w_hold ? r_grant_id : w_pick_idx;
    w_accept     = (r_state == ARB) && !bus.tx_busy && (w_hold || w_pick_found);
    w_burst_next = w_hold ? (r_burst_cnt + 4'd1) : 4'd1;
    w_hold_ends  = !w_hold || (w_burst_next == 4'(MAX_BURST));
    w_timeout    = (r_state == WAIT_ACK) && !bus.tx_busy && (r_to_cnt == TO_W'(ACK_TIMEOUT - 1));
    w_sel_data   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_winner == IDX_W'(k)) begin
        w_sel_data = bus.req_data[k*BYTE_W +: BYTE_W];
      end
    end
  end

  // State register; reset drops straight back to arbitration even mid-frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ARB;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB:       if (w_accept) w_next_state = ISSUE;
      ISSUE:     w_next_state = WAIT_ACK;
      WAIT_ACK:  begin
        if (bus.tx_busy) begin
          w_next_state = WAIT_DONE;
        end else if (w_timeout) begin
          w_next_state = ARB;
        end
      end
      WAIT_DONE: if (!bus.tx_busy) w_next_state = ARB;
      default:   w_next_state = ARB;
    endcase
  end

  // Combinational outputs: one-hot accept only in the cycle a byte is taken.
  always_comb begin
    bus.req_ready = '0;
    if (w_accept) begin
      bus.req_ready[w_winner] = 1'b1;
    end
    bus.arb_busy = (r_state != ARB);
  end

  // Registered datapath: captured byte, start pulse, burst/pointer bookkeeping, ack timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_burst_cnt   <= '0;
      r_to_cnt      <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_accept) begin
            r_tx_data   <= w_sel_data;
            r_grant_id  <= w_winner;
            r_tx_start  <= 1'b1;
            r_burst_cnt <= w_burst_next;
            if (w_hold_ends) begin
              r_rr_ptr <= incWrap(w_winner);
            end
          end else begin
            r_burst_cnt <= '0;
          end
        end
        ISSUE: begin
          r_tx_start <= 1'b0;
          r_to_cnt   <= '0;
        end
        WAIT_ACK: begin
          if (w_timeout) begin
            r_err_timeout <= 1'b1;
            r_burst_cnt   <= '0;
            r_rr_ptr      <= incWrap(r_grant_id);
          end else if (!bus.tx_busy) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.tx_start    = r_tx_start;
  assign bus.tx_data     = r_tx_data;
  assign bus.grant_id    = r_grant_id;
  assign bus.err_timeout = r_err_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios, a uart_tx busy model and a cycle-level reference model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int MAX_BURST   = 2;
  localparam int ACK_TIMEOUT = 16;
  localparam int FRAME       = 6;
  localparam int IDX_W       = 2;

  logic clk       = 1'b0;
  logic reset     = 1'b1;
  logic uartOn    = 1'b1;
  logic forceBusy = 1'b0;
  logic autoBusy  = 1'b0;
  int   busyLeft  = 0;

  int testsRun    = 0;
  int testsFailed = 0;
  int gotIdx;
  int grantLog[$];
  int expOrderAll[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int expOrderBrk[2] = '{1, 2};

  // Reference model: "free to grant", how far into the current transfer we are, and the fairness bookkeeping.
  logic       mIdle   = 1'b1;
  int         mAge    = 0;
  logic       mAcked  = 1'b0;
  int         mWait   = 0;
  int         mPtr    = 0;
  int         mBurst  = 0;
  int         mGrant  = 0;
  logic [7:0] mData   = 8'h00;
  logic       mStart  = 1'b0;
  logic       mErr    = 1'b0;
  logic [NUM_REQ-1:0] cmpReady;
  int         cmpWin;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .MAX_BURST   (MAX_BURST),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.tx_busy = autoBusy | forceBusy;

  // uart_tx stand-in: a start pulse raises busy for FRAME cycles; it shares the reset net.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      autoBusy <= 1'b0;
      busyLeft <= 0;
    end else if (uartOn && bus.tx_start) begin
      autoBusy <= 1'b1;
      busyLeft <= FRAME;
    end else if (busyLeft > 0) begin
      busyLeft <= busyLeft - 1;
      autoBusy <= (busyLeft > 1);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic validOf(input int i);
    return bus.req_valid[IDX_W'(i)];
  endfunction

  function automatic logic modelIsHold();
    return (mBurst > 0) && (mBurst < MAX_BURST) && validOf(mGrant);
  endfunction

  // Who may be granted right now: the open burst owner, else first valid scanning up from the pointer.
  function automatic int modelWinner();
    if (modelIsHold()) return mGrant;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (validOf((mPtr + k) % NUM_REQ)) return (mPtr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // Advance the reference model one clock using the inputs that were stable before the edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mIdle <= 1'b1; mAge <= 0; mAcked <= 1'b0; mWait <= 0; mPtr <= 0;
      mBurst <= 0; mGrant <= 0; mData <= 8'h00; mStart <= 1'b0; mErr <= 1'b0;
    end else if (mIdle) begin
      if (!bus.tx_busy && modelWinner() >= 0) begin
        mBurst <= modelIsHold() ? mBurst + 1 : 1;
        if (!modelIsHold() || (mBurst + 1 == MAX_BURST)) mPtr <= (modelWinner() + 1) % NUM_REQ;
        mGrant <= modelWinner();
        mData  <= 8'(bus.req_data >> (8 * modelWinner()));
        mStart <= 1'b1;
        mIdle  <= 1'b0;
        mAge   <= 0;
        mAcked <= 1'b0;
        mWait  <= 0;
      end else begin
        mBurst <= 0;
      end
    end else if (mAge == 0) begin
      mStart <= 1'b0;
      mAge   <= 1;
    end else if (!mAcked) begin
      if (bus.tx_busy) begin
        mAcked <= 1'b1;
      end else if (mWait == ACK_TIMEOUT - 1) begin
        mErr   <= 1'b1;
        mBurst <= 0;
        mPtr   <= (mGrant + 1) % NUM_REQ;
        mIdle  <= 1'b1;
      end else begin
        mWait <= mWait + 1;
      end
    end else if (!bus.tx_busy) begin
      mIdle <= 1'b1;
    end
  end

  // Compare every DUT output with the model on each falling edge while out of reset.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      cmpReady = '0;
      if (mIdle && !bus.tx_busy) begin
        cmpWin = modelWinner();
        if (cmpWin >= 0) cmpReady[IDX_W'(cmpWin)] = 1'b1;
      end
      checkOutput("req_ready", 32'(bus.req_ready), 32'(cmpReady));
      checkOutput("req_ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
      checkOutput("arb_busy", 32'(bus.arb_busy), 32'(!mIdle));
      checkOutput("tx_start", 32'(bus.tx_start), 32'(mStart));
      checkOutput("tx_data", 32'(bus.tx_data), 32'(mData));
      checkOutput("grant_id", 32'(bus.grant_id), 32'(mGrant));
      checkOutput("err_timeout", 32'(bus.err_timeout), 32'(mErr));
    end
  end

  task automatic tickN(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic [31:0] data);
    bus.req_valid = valid;
    bus.req_data  = data;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    tickN(2);
    reset = 1'b1;
  endtask

  // Wait (bounded) for a handshake, log the granted index, return just after the accepting edge.
  task automatic waitAccept(output int idx);
    idx = -1;
    for (int c = 0; c < 200 && idx < 0; c++) begin
      @(negedge clk);
      if ((bus.req_ready & bus.req_valid) != '0) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (bus.req_ready[IDX_W'(k)]) idx = k;
        end
      end
    end
    if (idx < 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL accept_wait: got no grant within 200 cycles, expected one");
    end else begin
      grantLog.push_back(idx);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle();
    int c = 0;
    tickN(1);
    while ((bus.arb_busy || bus.tx_busy) && c < 200) begin
      tickN(1);
      c++;
    end
    if (c >= 200) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL idle_wait: got arb_busy=%0b tx_busy=%0b after 200 cycles, expected both 0", bus.arb_busy, bus.tx_busy);
    end
  endtask

  task automatic checkOrder(input string name, input int expected[], input int n);
    checkOutput({name, "_count"}, 32'(grantLog.size()), 32'(n));
    for (int i = 0; i < n && i < grantLog.size(); i++) begin
      checkOutput($sformatf("%s_%0d", name, i), 32'(grantLog[i]), 32'(expected[i]));
    end
  endtask

  initial begin
    applyStimulus('0, '0);
    #2 reset = 1'b0;
    tickN(2);
    checkOutput("rst_tx_start", 32'(bus.tx_start), 32'd0);
    checkOutput("rst_tx_data", 32'(bus.tx_data), 32'd0);
    checkOutput("rst_grant_id", 32'(bus.grant_id), 32'd0);
    checkOutput("rst_err", 32'(bus.err_timeout), 32'd0);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_arb_busy", 32'(bus.arb_busy), 32'd0);
    reset = 1'b1;
    tickN(2);

    // Single requester: one accept, start next cycle, data held through the frame.
    applyStimulus(4'b0001, 32'h0000_0055);
    waitAccept(gotIdx);
    checkOutput("single_grant", 32'(gotIdx), 32'd0);
    checkOutput("single_start", 32'(bus.tx_start), 32'd1);
    checkOutput("single_data", 32'(bus.tx_data), 32'h55);
    checkOutput("single_ready_drop", 32'(bus.req_ready), 32'd0);
    applyStimulus(4'b0000, 32'hFFFF_FFFF);
    tickN(1);
    checkOutput("single_start_pulse", 32'(bus.tx_start), 32'd0);
    tickN(2);
    checkOutput("single_busy", 32'(bus.tx_busy), 32'd1);
    checkOutput("single_data_hold", 32'(bus.tx_data), 32'h55);
    waitIdle();
    checkOutput("single_data_after", 32'(bus.tx_data), 32'h55);

    // All four continuously valid with bursts of two.
    doReset();
    grantLog.delete();
    applyStimulus(4'b1111, 32'h4332_2110);
    for (int i = 0; i < 9; i++) waitAccept(gotIdx);
    applyStimulus(4'b0000, 32'h0);
    checkOrder("rr_order", expOrderAll, 9);
    waitIdle();

    // Burst break: requester 1 offers one byte only while 2 stays valid.
    doReset();
    grantLog.delete();
    applyStimulus(4'b0110, 32'h00B2_B100);
    waitAccept(gotIdx);
    applyStimulus(4'b0100, 32'h00B2_B100);
    waitAccept(gotIdx);
    applyStimulus(4'b0000, 32'h0);
    checkOrder("brk_order", expOrderBrk, 2);
    waitIdle();

    // Ack timeout: uart_tx never answers the start pulse.
    uartOn = 1'b0;
    applyStimulus(4'b1001, 32'hD300_00D0);
    waitAccept(gotIdx);
    checkOutput("to_first_grant", 32'(gotIdx), 32'd3);
    tickN(1);
    for (int c = 1; c <= ACK_TIMEOUT; c++) begin
      tickN(1);
      if (c == ACK_TIMEOUT - 1) begin
        checkOutput("to_err_early", 32'(bus.err_timeout), 32'd0);
        checkOutput("to_busy_early", 32'(bus.arb_busy), 32'd1);
      end
      if (c == ACK_TIMEOUT) begin
        checkOutput("to_err_set", 32'(bus.err_timeout), 32'd1);
        checkOutput("to_back_arb", 32'(bus.arb_busy), 32'd0);
      end
    end
    uartOn = 1'b1;
    waitAccept(gotIdx);
    checkOutput("to_next_grant", 32'(gotIdx), 32'd0);
    applyStimulus(4'b0000, 32'h0);
    waitIdle();
    checkOutput("to_err_sticky", 32'(bus.err_timeout), 32'd1);

    // External busy holds off any grant until it clears.
    forceBusy = 1'b1;
    applyStimulus(4'b1000, 32'hE300_0000);
    for (int c = 0; c < 5; c++) begin
      tickN(1);
      checkOutput("busy_block", 32'(bus.req_ready), 32'd0);
    end
    forceBusy = 1'b0;
    waitAccept(gotIdx);
    checkOutput("busy_grant", 32'(gotIdx), 32'd3);
    checkOutput("busy_data", 32'(bus.tx_data), 32'hE3);
    applyStimulus(4'b0000, 32'h0);
    waitIdle();

    // Reset in the middle of a frame, then a fresh grant.
    applyStimulus(4'b0001, 32'h0000_00A5);
    waitAccept(gotIdx);
    applyStimulus(4'b0000, 32'h0);
    tickN(3);
    checkOutput("mid_busy", 32'(bus.tx_busy), 32'd1);
    checkOutput("mid_arb_busy", 32'(bus.arb_busy), 32'd1);
    checkOutput("mid_data", 32'(bus.tx_data), 32'hA5);
    #2 reset = 1'b0;
    #1;
    checkOutput("arst_tx_start", 32'(bus.tx_start), 32'd0);
    checkOutput("arst_tx_data", 32'(bus.tx_data), 32'd0);
    checkOutput("arst_grant_id", 32'(bus.grant_id), 32'd0);
    checkOutput("arst_err", 32'(bus.err_timeout), 32'd0);
    checkOutput("arst_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("arst_arb_busy", 32'(bus.arb_busy), 32'd0);
    checkOutput("arst_tx_busy", 32'(bus.tx_busy), 32'd0);
    applyStimulus(4'b0100, 32'h0077_0000);
    tickN(1);
    reset = 1'b1;
    waitAccept(gotIdx);
    checkOutput("arst_grant", 32'(gotIdx), 32'd2);
    checkOutput("arst_new_data", 32'(bus.tx_data), 32'h77);
    applyStimulus(4'b0000, 32'h0);
    waitIdle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
